// File: rtl/load_store_unit_if.sv
// rtl/load_store_unit_if.sv - core-side and data_memory-side signals of the load/store unit
interface load_store_unit_if;
    // core datapath side
    logic        req;
    logic        wr;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        stall;
    logic        misalign;
    logic        err;
    // data_memory side
    logic        mem_we;
    logic [31:0] mem_a;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    // Core plus memory environment: drives requests and read data, observes results
    modport master (
        output req, wr, funct3, addr, wdata, mem_rd,
        input  rdata, stall, misalign, err, mem_we, mem_a, mem_wd
    );

    // The load/store unit itself
    modport slave (
        input  req, wr, funct3, addr, wdata, mem_rd,
        output rdata, stall, misalign, err, mem_we, mem_a, mem_wd
    );
endinterface

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - RV32I load/store unit: sub-word loads, RMW sub-word stores; option macro LSU_MISALIGN_TRAP_EN
module load_store_unit (
    input  logic              clk,
    input  logic              rst_n,
    load_store_unit_if.slave  bus
);

    typedef enum logic {
        IDLE  = 1'b0,
        WRITE = 1'b1
    } state_t;

    state_t      state;
    logic [31:0] merge_q;
    logic [29:0] a_q;

    logic        is_b;
    logic        is_h;
    logic        is_w;
    logic        is_unsigned;
    logic        valid;
    logic        access;
    logic [1:0]  lane;
    logic        in_idle;
    logic        live;
    logic        launch_rmw;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_val;
    logic [31:0] merged;

    // Size code decode; anything not B/H/W/BU/HU leaves all flags low
    always_comb begin
        is_b        = 1'b0;
        is_h        = 1'b0;
        is_w        = 1'b0;
        is_unsigned = 1'b0;
        case (bus.funct3)
            3'b000: is_b = 1'b1;
            3'b001: is_h = 1'b1;
            3'b010: is_w = 1'b1;
            3'b100: begin
                is_b        = 1'b1;
                is_unsigned = 1'b1;
            end
            3'b101: begin
                is_h        = 1'b1;
                is_unsigned = 1'b1;
            end
            default: ;
        endcase
    end

    assign valid   = is_b | is_h | is_w;
    assign in_idle = (state == IDLE);
    // Outputs are only live outside reset and in IDLE; WRITE ignores all inputs
    assign live    = rst_n & in_idle;

`ifdef LSU_MISALIGN_TRAP_EN
    logic misaligned;
    logic err_q;

    assign misaligned   = (is_h & bus.addr[0]) | (is_w & (bus.addr[1:0] != 2'b00));
    assign lane         = bus.addr[1:0];
    // A misaligned access is suppressed entirely and only raises the flag
    assign access       = bus.req & valid & ~misaligned;
    assign bus.misalign = live & bus.req & misaligned;
    assign bus.err      = err_q;

    // Sticky error: set on any edge that sees a misaligned request
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (bus.misalign) begin
            err_q <= 1'b1;
        end
    end
`else
    // Offending low bits are forced to zero so the access proceeds aligned
    assign lane         = {bus.addr[1] & ~is_w, bus.addr[0] & is_b};
    assign access       = bus.req & valid;
    assign bus.misalign = 1'b0;
    assign bus.err      = 1'b0;
`endif

    assign launch_rmw = live & access & bus.wr & ~is_w;

    // Extract the addressed lane from the asynchronously read word and extend it
    always_comb begin
        case (lane)
            2'd0:    byte_sel = bus.mem_rd[7:0];
            2'd1:    byte_sel = bus.mem_rd[15:8];
            2'd2:    byte_sel = bus.mem_rd[23:16];
            default: byte_sel = bus.mem_rd[31:24];
        endcase
        half_sel = lane[1] ? bus.mem_rd[31:16] : bus.mem_rd[15:0];
        if (is_b) begin
            load_val = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
        end else if (is_h) begin
            load_val = {{16{~is_unsigned & half_sel[15]}}, half_sel};
        end else begin
            load_val = bus.mem_rd;
        end
    end

    // Old word with the store byte/halfword spliced into its lane
    always_comb begin
        merged = bus.mem_rd;
        if (is_b) begin
            case (lane)
                2'd0:    merged[7:0]   = bus.wdata[7:0];
                2'd1:    merged[15:8]  = bus.wdata[7:0];
                2'd2:    merged[23:16] = bus.wdata[7:0];
                default: merged[31:24] = bus.wdata[7:0];
            endcase
        end else if (is_h) begin
            if (lane[1]) begin
                merged[31:16] = bus.wdata[15:0];
            end else begin
                merged[15:0]  = bus.wdata[15:0];
            end
        end
    end

    // In WRITE the captured address and merged word drive memory; reset kills the write at once
    assign bus.mem_a  = in_idle ? {2'b00, bus.addr[31:2]} : {2'b00, a_q};
    assign bus.mem_wd = in_idle ? bus.wdata : merge_q;
    assign bus.mem_we = rst_n & (~in_idle | (access & bus.wr & is_w));
    assign bus.stall  = launch_rmw;
    assign bus.rdata  = (live & access & ~bus.wr) ? load_val : 32'd0;

    // Two-state RMW sequencer: capture merge and address on launch, write back next cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            merge_q <= 32'd0;
            a_q     <= 30'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch_rmw) begin
                        merge_q <= merged;
                        a_q     <= bus.addr[31:2];
                        state   <= WRITE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
